// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared types, default generators and parity helper for the convolutional encoder
package conv_enc_pkg;
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
   localparam int KMAX = 9;
   localparam logic [5:0] G_K3_R12 = 6'b111_101;
   function automatic logic parity(input logic [KMAX-1:0] w, input logic [KMAX-1:0] g);
      return ^(w & g);
   endfunction
endpackage

// File: rtl/conv_enc_punct.sv
// conv_enc_punct: puncture phase counter and keep-mask register
// Ports: clk, reset (sync, active-high); load = a codeword is loaded this cycle;
// start = that codeword opens a new frame (phase restarts at 0); mask = keep-mask of the loaded codeword.
module conv_enc_punct #(
   parameter int N = 2,
   parameter int PUNCT_P = 2,
   parameter logic [N*PUNCT_P-1:0] PUNCT_PATTERN = 4'b01_11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         start,
   output logic [N-1:0] mask
);
   localparam int PW = PUNCT_P > 1 ? $clog2(PUNCT_P) : 1;
   logic [PW-1:0] phase, ph;
   assign ph = start ? '0 : phase;
   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
         mask  <= '1;
      end else if (load) begin
         mask  <= PUNCT_PATTERN[int'(ph)*N +: N];
         phase <= (ph == PW'(PUNCT_P-1)) ? '0 : ph + PW'(1);
      end
   end
endmodule

// File: rtl/conv_encoder_param.sv
// conv_encoder_param: rate-1/N feed-forward convolutional encoder with zero-tail or truncated frames
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_last = information bit stream;
// cfg_terminate = append K-1 zero tail bits (latched on a frame's first bit);
// out_valid/out_ready/out_data/out_mask/out_last = codeword stream; frame_cnt = completed frames.
// Optional: CONV_ENC_PUNCT_EN drives out_mask from the puncture pattern, otherwise it is all ones.
module conv_encoder_param import conv_enc_pkg::*; #(
   parameter int K = 3,
   parameter int N = 2,
   parameter logic [N*K-1:0] G = G_K3_R12,
   parameter int PUNCT_P = 2,
   parameter logic [N*PUNCT_P-1:0] PUNCT_PATTERN = 4'b01_11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_data,
   input  logic         in_last,
   input  logic         cfg_terminate,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [N-1:0] out_mask,
   output logic         out_last,
   output logic [15:0]  frame_cnt
);
   state_t state, state_n;
   logic [K-2:0] mem;
   logic [K-1:0] win;
   logic [N-1:0] cw;
   logic [3:0] tcnt;
   logic term_q, term_eff, load_ok, acc, tail_go, tail_end, load, frame_start, cut;
   assign load_ok     = !out_valid || out_ready;
   assign in_ready    = (state != TAIL) && load_ok;
   assign acc         = in_valid && in_ready;
   assign tail_go     = (state == TAIL) && load_ok;
   assign tail_end    = tail_go && (tcnt == 4'(K-2));
   assign load        = acc || tail_go;
   assign frame_start = acc && (state == IDLE);
   // the first bit of a frame uses the live config, later bits the latched one
   assign term_eff    = (state == IDLE) ? cfg_terminate : term_q;
   assign cut         = in_last && !term_eff;
   // tail cycles shift a zero into the window
   assign win         = {mem, acc ? in_data : 1'b0};
   always_comb begin
      cw = '0;
      for (int i = 0; i < N; i++) cw[i] = parity(KMAX'(win), KMAX'(G[i*K +: K]));
   end
   always_comb begin
      state_n = acc ? (in_last ? (term_eff ? TAIL : IDLE) : DATA) : (tail_end ? IDLE : state);
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mem       <= '0;
         tcnt      <= '0;
         term_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (frame_start) term_q <= cfg_terminate;
         if (out_valid && out_ready && out_last) frame_cnt <= frame_cnt + 16'd1;
         if (load) out_data <= cw;
         out_valid <= load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
         if (acc) begin
            out_last <= cut;
            mem      <= cut ? '0 : win[K-2:0];
            tcnt     <= '0;
         end else if (tail_go) begin
            out_last <= tail_end;
            mem      <= tail_end ? '0 : win[K-2:0];
            tcnt     <= tcnt + 4'd1;
         end
      end
   end
`ifdef CONV_ENC_PUNCT_EN
   conv_enc_punct #(.N(N), .PUNCT_P(PUNCT_P), .PUNCT_PATTERN(PUNCT_PATTERN)) u_punct (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .start (frame_start),
      .mask  (out_mask)
   );
`else
   assign out_mask = '1;
`endif
endmodule

// File: tb/tb_conv_encoder_param.sv
// tb_conv_encoder_param: table-driven scoreboard bench for conv_encoder_param (K=3, N=2 defaults)
module tb_conv_encoder_param;
   logic clk = 1'b0;
   logic reset, in_valid, in_data, in_last, cfg_terminate, out_ready;
   logic in_ready, out_valid, out_last;
   logic [1:0] out_data, out_mask;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   conv_encoder_param dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .cfg_terminate (cfg_terminate),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_mask      (out_mask),
      .out_last      (out_last),
      .frame_cnt     (frame_cnt)
   );

`ifdef CONV_ENC_PUNCT_EN
   localparam bit PUNCT = 1'b1;
`else
   localparam bit PUNCT = 1'b0;
`endif

   typedef struct packed {logic [1:0] d; logic l; logic [1:0] m;} exp_t;
   typedef struct {logic [15:0] bits; int len; logic term; logic [31:0] cw; int ncw;} vec_t;

   exp_t q[$];
   vec_t tv[5];
   int total = 0, passed = 0, stall_left = 0, pops = 0, st = 0;
   logic acc_seen = 1'b0, was_stalled = 1'b0, held_l = 1'b0;
   logic [1:0] held_d = '0, held_m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [1:0] mask_of(input int k);
      return (PUNCT && (k % 2 == 1)) ? 2'b01 : 2'b11;
   endfunction

   task automatic push_cw(input logic [1:0] d, input logic l, input int k);
      exp_t e;
      e.d = d;
      e.l = l;
      e.m = mask_of(k);
      q.push_back(e);
   endtask

   task automatic push_frame(input vec_t v);
      for (int k = 0; k < v.ncw; k++) push_cw(v.cw[2*k +: 2], k == v.ncw - 1, k);
   endtask

   // one clock: drive out_ready, observe at negedge, return 1 time unit after posedge
   task automatic tick;
      exp_t e;
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else out_ready = 1'b1;
      @(negedge clk);
      acc_seen = in_valid && in_ready;
      if (!reset && out_valid && !out_ready) begin
         chk("stall_in_ready", 32'(in_ready), 0);
         if (was_stalled) chk("stall_hold", {27'd0, out_data, out_last, out_mask}, {27'd0, held_d, held_l, held_m});
         was_stalled = 1'b1;
         held_d = out_data;
         held_l = out_last;
         held_m = out_mask;
      end else was_stalled = 1'b0;
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_cw: got %b with empty scoreboard", out_data);
         end else begin
            e = q.pop_front();
            pops++;
            chk("cw_data", 32'(out_data), 32'(e.d));
            chk("cw_last", 32'(out_last), 32'(e.l));
            chk("cw_mask", 32'(out_mask), 32'(e.m));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic d, input logic l, input logic t, output int stalls);
      logic acc;
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      cfg_terminate = t;
      stalls = 0;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         tick;
         acc = acc_seen;
         if (!acc) stalls++;
      end
      chk("accepted", 32'(acc), 1);
   endtask

   task automatic drain;
      for (int i = 0; i < 100 && q.size() != 0; i++) tick;
      chk("drain_empty", 32'(q.size()), 0);
      repeat (3) tick;
   endtask

   initial begin
      tv[0] = '{16'b1101,  4, 1'b1, 32'b11_01_01_00_10_11,    6};
      tv[1] = '{16'b1101,  4, 1'b0, 32'b01_00_10_11,          4};
      tv[2] = '{16'b1,     1, 1'b0, 32'b11,                   1};
      tv[3] = '{16'b1,     1, 1'b1, 32'b11_10_11,             3};
      tv[4] = '{16'b10110, 5, 1'b1, 32'b11_10_00_01_01_11_00, 7};
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 1'b0;
      in_last = 1'b0;
      cfg_terminate = 1'b0;
      out_ready = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_mask", 32'(out_mask), 32'h3);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      // back-to-back frames; the first bit of a frame after a terminated one waits out the K-1 tail
      for (int i = 0; i < 5; i++) begin
         push_frame(tv[i]);
         for (int b = 0; b < tv[i].len; b++) begin
            send_bit(tv[i].bits[b], b == tv[i].len - 1, (b == 0) ? tv[i].term : !tv[i].term, st);
            if (b == 0) chk("first_bit_stall", 32'(st), (i > 0 && tv[i-1].term) ? 2 : 0);
         end
      end
      in_valid = 1'b0;
      drain;
      chk("frame_cnt_5", 32'(frame_cnt), 5);
      // downstream stalls for 3 cycles mid-frame
      pops = 0;
      push_frame(tv[4]);
      for (int b = 0; b < tv[4].len; b++) begin
         if (b == 2) stall_left = 3;
         send_bit(tv[4].bits[b], b == tv[4].len - 1, tv[4].term, st);
         if (b == 2) chk("bp_stall_cycles", 32'(st), 3);
      end
      in_valid = 1'b0;
      drain;
      chk("bp_cw_count", 32'(pops), 7);
      chk("frame_cnt_6", 32'(frame_cnt), 6);
      // reset while the tail is pending
      push_cw(2'b11, 1'b0, 0);
      send_bit(1'b1, 1'b0, 1'b1, st);
      send_bit(1'b1, 1'b1, 1'b0, st);
      in_valid = 1'b0;
      stall_left = 1;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("tailrst_out_valid", 32'(out_valid), 0);
      chk("tailrst_in_ready", 32'(in_ready), 1);
      chk("tailrst_out_last", 32'(out_last), 0);
      chk("tailrst_out_mask", 32'(out_mask), 32'h3);
      chk("tailrst_frame_cnt", 32'(frame_cnt), 0);
      chk("tailrst_sb_empty", 32'(q.size()), 0);
      push_frame(tv[2]);
      send_bit(1'b1, 1'b1, 1'b0, st);
      in_valid = 1'b0;
      drain;
      chk("frame_cnt_after_rst", 32'(frame_cnt), 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
